// File: rtl/pcm_sample_buffer.sv
// pcm_sample_buffer
// Channel-select circular sample buffer sitting between the 24-bit I2S
// capture stage and ready/valid sample consumers. One channel is stored per
// capture strobe into a block RAM with a registered read port; the RAM output
// register doubles as the output slot of the read stream.
module pcm_sample_buffer #(
    parameter int DEPTH       = 512,
    parameter int BLOCK_LEN   = 256,
    parameter int SELECT_LEFT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sample_valid_i,
    input  logic [23:0]              left_sample_i,
    input  logic [23:0]              right_sample_i,
    input  logic                     flush_i,
    output logic [23:0]              read_data_o,
    output logic                     read_valid_o,
    input  logic                     read_ready_i,
    output logic                     buffer_ready_o,
    output logic [$clog2(DEPTH)+1:0] fill_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = AW + 2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [FW-1:0] BLOCK_C = FW'(BLOCK_LEN);

    // Storage and state
    logic [23:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] mem_count_r;
    logic [23:0]   read_data_r;
    logic          read_valid_r;
    logic [FW-1:0] fill_r;
    logic          buffer_ready_r;
    logic          overflow_r;

    // Next-state / control
    logic [23:0]   sample_sel_s;
    logic          mem_full_s;
    logic          wr_en_s;
    logic          drop_s;
    logic          fetch_s;
    logic [CW-1:0] mem_count_nxt_s;
    logic          read_valid_nxt_s;
    logic [FW-1:0] fill_nxt_s;

    // Pick the channel this instance captures.
    always_comb begin
        if (SELECT_LEFT != 0) begin
            sample_sel_s = left_sample_i;
        end else begin
            sample_sel_s = right_sample_i;
        end
    end

    // Write/fetch/drop decisions; flush suppresses everything this cycle.
    always_comb begin
        mem_full_s = (mem_count_r == DEPTH_C);
        wr_en_s    = 1'b0;
        drop_s     = 1'b0;
        fetch_s    = 1'b0;
        if (flush_i) begin
            wr_en_s = 1'b0;
            drop_s  = 1'b0;
            fetch_s = 1'b0;
        end else begin
            // Fullness is judged on the start-of-cycle count, so a fetch in
            // the same cycle does not make room for a write.
            wr_en_s = sample_valid_i && !mem_full_s;
            drop_s  = sample_valid_i && mem_full_s;
            fetch_s = (mem_count_r != {CW{1'b0}}) && (!read_valid_r || read_ready_i);
        end
    end

    // Next RAM occupancy, output-slot state and total fill level.
    always_comb begin
        mem_count_nxt_s  = mem_count_r;
        read_valid_nxt_s = read_valid_r;
        if (flush_i) begin
            mem_count_nxt_s  = {CW{1'b0}};
            read_valid_nxt_s = 1'b0;
        end else begin
            case ({wr_en_s, fetch_s})
                2'b10:   mem_count_nxt_s = mem_count_r + CW'(1);
                2'b01:   mem_count_nxt_s = mem_count_r - CW'(1);
                default: mem_count_nxt_s = mem_count_r;
            endcase
            if (fetch_s) begin
                read_valid_nxt_s = 1'b1;
            end else if (read_valid_r && read_ready_i) begin
                read_valid_nxt_s = 1'b0;
            end else begin
                read_valid_nxt_s = read_valid_r;
            end
        end
        fill_nxt_s = {{(FW-CW){1'b0}}, mem_count_nxt_s} + {{(FW-1){1'b0}}, read_valid_nxt_s};
    end

    // Pointer, occupancy, status and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            mem_count_r    <= {CW{1'b0}};
            read_valid_r   <= 1'b0;
            fill_r         <= {FW{1'b0}};
            buffer_ready_r <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr_r   <= {AW{1'b0}};
                rd_ptr_r   <= {AW{1'b0}};
                overflow_r <= 1'b0;
            end else begin
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (fetch_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
            mem_count_r    <= mem_count_nxt_s;
            read_valid_r   <= read_valid_nxt_s;
            fill_r         <= fill_nxt_s;
            buffer_ready_r <= (fill_nxt_s >= BLOCK_C);
        end
    end

    // RAM write port; contents are not cleared by reset or flush.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= sample_sel_s;
        end
    end

    // Registered RAM read, which is also the held output slot while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_data_r <= 24'd0;
        end else if (fetch_s) begin
            read_data_r <= mem_r[rd_ptr_r];
        end
    end

    assign read_data_o    = read_data_r;
    assign read_valid_o   = read_valid_r;
    assign fill_o         = fill_r;
    assign buffer_ready_o = buffer_ready_r;
    assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Testbench for pcm_sample_buffer. Three instances (deep/left, 8-word/left,
// 4-word/right) share one stimulus stream; each is compared every cycle with
// a queue-based reference model, plus directed checks for the key scenarios.
module tb_pcm_sample_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sample_valid_i = 1'b0;
    logic [23:0] left_sample_i = 24'd0;
    logic [23:0] right_sample_i = 24'd0;
    logic        flush_i = 1'b0;
    logic        read_ready_i = 1'b0;

    logic [23:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;
    logic        o0, o1, o2;
    logic [10:0] f0;
    logic [4:0]  f1;
    logic [3:0]  f2;

    always #5 clk_i = ~clk_i;

    pcm_sample_buffer #(.DEPTH(512), .BLOCK_LEN(256), .SELECT_LEFT(1)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i),
        .left_sample_i(left_sample_i), .right_sample_i(right_sample_i),
        .flush_i(flush_i), .read_data_o(d0), .read_valid_o(v0),
        .read_ready_i(read_ready_i), .buffer_ready_o(b0), .fill_o(f0),
        .overflow_o(o0));

    pcm_sample_buffer #(.DEPTH(8), .BLOCK_LEN(4), .SELECT_LEFT(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i),
        .left_sample_i(left_sample_i), .right_sample_i(right_sample_i),
        .flush_i(flush_i), .read_data_o(d1), .read_valid_o(v1),
        .read_ready_i(read_ready_i), .buffer_ready_o(b1), .fill_o(f1),
        .overflow_o(o1));

    pcm_sample_buffer #(.DEPTH(4), .BLOCK_LEN(1), .SELECT_LEFT(0)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i),
        .left_sample_i(left_sample_i), .right_sample_i(right_sample_i),
        .flush_i(flush_i), .read_data_o(d2), .read_valid_o(v2),
        .read_ready_i(read_ready_i), .buffer_ready_o(b2), .fill_o(f2),
        .overflow_o(o2));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: RAM contents as a queue, plus the output slot.
    logic [23:0] mq [3][$];
    logic [23:0] md [3] = '{24'd0, 24'd0, 24'd0};
    bit          mv [3] = '{1'b0, 1'b0, 1'b0};
    bit          mo [3] = '{1'b0, 1'b0, 1'b0};
    int          mdepth [3] = '{512, 8, 4};
    int          mblk   [3] = '{256, 4, 1};
    bit          msel   [3] = '{1'b1, 1'b1, 1'b0};

    logic [23:0] got0 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        int n;
        bit fetch;
        if (flush_i) begin
            mq[k].delete();
            mv[k] = 1'b0;
            mo[k] = 1'b0;
        end else begin
            n = mq[k].size();
            fetch = (n != 0) && (!mv[k] || read_ready_i);
            if (fetch) begin
                md[k] = mq[k].pop_front();
                mv[k] = 1'b1;
            end else if (mv[k] && read_ready_i) begin
                mv[k] = 1'b0;
            end
            if (sample_valid_i) begin
                if (n < mdepth[k]) mq[k].push_back(msel[k] ? left_sample_i : right_sample_i);
                else mo[k] = 1'b1;
            end
        end
    endtask

    task automatic check_inst(input int k);
        logic [23:0] d;
        logic v, b, o;
        int f, fe;
        case (k)
            0: begin d = d0; v = v0; b = b0; o = o0; f = int'(f0); end
            1: begin d = d1; v = v1; b = b1; o = o1; f = int'(f1); end
            default: begin d = d2; v = v2; b = b2; o = o2; f = int'(f2); end
        endcase
        fe = mq[k].size() + int'(mv[k]);
        check($sformatf("i%0d_valid", k), {31'd0, v}, {31'd0, mv[k]});
        check($sformatf("i%0d_data", k), {8'd0, d}, {8'd0, md[k]});
        check($sformatf("i%0d_fill", k), f, fe);
        check($sformatf("i%0d_bufrdy", k), {31'd0, b}, (fe >= mblk[k]) ? 32'd1 : 32'd0);
        check($sformatf("i%0d_ovf", k), {31'd0, o}, {31'd0, mo[k]});
    endtask

    // Advance the model on every edge; reset clears it asynchronously.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                mv[k] = 1'b0;
                mo[k] = 1'b0;
                md[k] = 24'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    // Record samples accepted by the consumer of the deep instance.
    always @(posedge clk_i) begin
        if (!rst_i && v0 && read_ready_i) got0.push_back(d0);
    end

    // Compare all instances with the model away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) check_inst(k);
        end
    end

    task automatic cyc(input bit sv, input logic [23:0] l, input logic [23:0] r,
                       input bit rdy, input bit fl);
        @(negedge clk_i);
        sample_valid_i = sv;
        left_sample_i  = l;
        right_sample_i = r;
        read_ready_i   = rdy;
        flush_i        = fl;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 24'd0, 24'd0, rdy, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk_en = 1'b1;
        check("rst_valid", {31'd0, v0}, 32'd0);
        check("rst_data", {8'd0, d0}, 32'd0);
        check("rst_fill", {21'd0, f0}, 32'd0);
        check("rst_bufrdy", {31'd0, b0}, 32'd0);
        check("rst_ovf", {31'd0, o0}, 32'd0);
        rst_i = 1'b0;
        idle(2, 1'b1);

        // Three boundary values with ready high; valid two cycles after strobe.
        got0.delete();
        cyc(1'b1, 24'h000001, 24'h0A0A0A, 1'b1, 1'b0);
        cyc(1'b1, 24'h7FFFFF, 24'h0B0B0B, 1'b1, 1'b0);
        check("lat_not_yet", {31'd0, v0}, 32'd0);
        cyc(1'b1, 24'h800000, 24'h0C0C0C, 1'b1, 1'b0);
        check("lat_valid", {31'd0, v0}, 32'd1);
        check("lat_data", {8'd0, d0}, 32'h000001);
        idle(5, 1'b1);
        check("seq_len", got0.size(), 32'd3);
        if (got0.size() == 3) begin
            check("seq0", {8'd0, got0[0]}, 32'h000001);
            check("seq1", {8'd0, got0[1]}, 32'h7FFFFF);
            check("seq2", {8'd0, got0[2]}, 32'h800000);
        end
        check("seq_ovf", {31'd0, o0}, 32'd0);

        // Channel select: right-channel instance stores the right sample.
        cyc(1'b1, 24'h111111, 24'h222222, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("sel_right", {8'd0, d2}, 32'h222222);
        check("sel_left", {8'd0, d0}, 32'h111111);

        // Fill the deep buffer with the consumer stalled.
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
        for (int i = 0; i < 513; i++) cyc(1'b1, 24'h100000 + 24'(i), 24'h200000 + 24'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        // 512 strobes leave 511 in RAM plus one in the slot; the 513th fills RAM.
        check("full_fill", {21'd0, f0}, 32'd513);
        check("full_ovf0", {31'd0, o0}, 32'd0);
        check("full_bufrdy", {31'd0, b0}, 32'd1);
        cyc(1'b1, 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("full_ovf1", {31'd0, o0}, 32'd1);
        check("full_fill2", {21'd0, f0}, 32'd513);
        got0.delete();
        idle(520, 1'b1);
        check("drain_len", got0.size(), 32'd513);
        for (int i = 0; i < got0.size() && i < 513; i++)
            check("drain_val", {8'd0, got0[i]}, 32'h100000 + 32'(i));

        // Block threshold on the 8-word instance.
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 24'h400000 + 24'(i), 24'd0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("blk_fill3", {27'd0, f1}, 32'd3);
        check("blk_rdy_lo", {31'd0, b1}, 32'd0);
        cyc(1'b1, 24'h400003, 24'd0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("blk_fill4", {27'd0, f1}, 32'd4);
        check("blk_rdy_hi", {31'd0, b1}, 32'd1);
        cyc(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b0);
        check("blk_accept_fill", {27'd0, f1}, 32'd3);
        check("blk_accept_rdy", {31'd0, b1}, 32'd0);

        // Wrap with a strobe every cycle and ready toggling.
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
        got0.delete();
        for (int i = 0; i < 20; i++) cyc(1'b1, 24'h300000 + 24'(i), 24'h310000 + 24'(i), (i % 2) == 0, 1'b0);
        idle(25, 1'b1);
        check("wrap_len", got0.size(), 32'd20);
        for (int i = 0; i < got0.size() && i < 20; i++)
            check("wrap_val", {8'd0, got0[i]}, 32'h300000 + 32'(i));

        // Flush with a simultaneous strobe.
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 24'h500000 + 24'(i), 24'h510000 + 24'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        check("pre_flush_fill", {21'd0, f0}, 32'd5);
        cyc(1'b1, 24'h777777, 24'h777777, 1'b0, 1'b1);
        cyc(1'b0, 24'd0, 24'd0, 1'b0, 1'b0);
        check("flush_fill", {21'd0, f0}, 32'd0);
        check("flush_valid", {31'd0, v0}, 32'd0);
        check("flush_ovf", {31'd0, o0}, 32'd0);
        idle(3, 1'b0);

        // Randomized traffic including rare flushes.
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        idle(20, 1'b1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1'b1, 24'h600000 + 24'(i), 24'h610000 + 24'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        check("pre_rst_valid", {31'd0, v0}, 32'd1);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", {31'd0, v0}, 32'd0);
        check("arst_data", {8'd0, d0}, 32'd0);
        check("arst_fill", {21'd0, f0}, 32'd0);
        check("arst_bufrdy", {31'd0, b0}, 32'd0);
        check("arst_ovf", {31'd0, o0}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc(1'b1, 24'h654321, 24'h123456, 1'b1, 1'b0);
        cyc(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        check("post_rst_lat0", {31'd0, v0}, 32'd0);
        cyc(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        check("post_rst_lat1", {31'd0, v0}, 32'd1);
        check("post_rst_data", {8'd0, d0}, 32'h654321);
        idle(5, 1'b1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
